// File: rtl/tri_raster_scan.sv
`default_nettype none
// ============================================================================
// Module   : tri_raster_scan
// Brief    : Clipped bounding-box raster walker feeding a point-in-triangle
//            tester and streaming per-pixel verdicts under valid/ready.
// Revision : 1.0
// ============================================================================
module tri_raster_scan #(
   parameter int CW       = 11,
   parameter int XMAX     = 639,
   parameter int YMAX     = 479,
   parameter bit EMIT_ALL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic signed [CW-1:0] v1x,
   input  logic signed [CW-1:0] v1y,
   input  logic signed [CW-1:0] v2x,
   input  logic signed [CW-1:0] v2y,
   input  logic signed [CW-1:0] v3x,
   input  logic signed [CW-1:0] v3y,
   output logic signed [CW-1:0] tp1x,
   output logic signed [CW-1:0] tp1y,
   output logic signed [CW-1:0] tp2x,
   output logic signed [CW-1:0] tp2y,
   output logic signed [CW-1:0] tp3x,
   output logic signed [CW-1:0] tp3y,
   output logic signed [CW-1:0] tptx,
   output logic signed [CW-1:0] tpty,
   output logic                 tst_req,
   input  logic                 tst_done,
   input  logic                 tst_in,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic signed [CW-1:0] pix_x,
   output logic signed [CW-1:0] pix_y,
   output logic                 pix_in,
   output logic                 busy,
   output logic                 done,
   output logic [19:0]          pix_cnt
);

   localparam logic signed [CW-1:0] c_zero = '0;
   localparam logic signed [CW-1:0] c_one  = CW'(1);
   localparam logic signed [CW-1:0] c_xmax = CW'(XMAX);
   localparam logic signed [CW-1:0] c_ymax = CW'(YMAX);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BBOX  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_EMIT  = 3'd4,
      S_STEP  = 3'd5,
      S_FIN   = 3'd6
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic signed [CW-1:0] r_tp1x, r_tp1y, r_tp2x, r_tp2y, r_tp3x, r_tp3y;
   logic signed [CW-1:0] r_tptx, r_tpty;
   logic signed [CW-1:0] r_xmin, r_xmax, r_ymax;
   logic signed [CW-1:0] r_pix_x, r_pix_y;
   logic                 r_pix_in;
   logic                 r_busy;
   logic [19:0]          r_pix_cnt;

   logic signed [CW-1:0] w_xlo, w_xhi, w_ylo, w_yhi;
   logic signed [CW-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
   logic                 w_empty;
   logic                 w_last;
   logic                 w_tst_req;
   logic                 w_pix_valid;
   logic                 w_done;

   function automatic logic signed [CW-1:0] min3(
      input logic signed [CW-1:0] a,
      input logic signed [CW-1:0] b,
      input logic signed [CW-1:0] c
   );
      logic signed [CW-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic signed [CW-1:0] max3(
      input logic signed [CW-1:0] a,
      input logic signed [CW-1:0] b,
      input logic signed [CW-1:0] c
   );
      logic signed [CW-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // Box is derived from the latched vertices, so it is valid during BBOX.
   always_comb begin
      w_xlo   = min3(r_tp1x, r_tp2x, r_tp3x);
      w_xhi   = max3(r_tp1x, r_tp2x, r_tp3x);
      w_ylo   = min3(r_tp1y, r_tp2y, r_tp3y);
      w_yhi   = max3(r_tp1y, r_tp2y, r_tp3y);
      w_xmin  = (w_xlo < c_zero) ? c_zero : w_xlo;
      w_xmax  = (w_xhi > c_xmax) ? c_xmax : w_xhi;
      w_ymin  = (w_ylo < c_zero) ? c_zero : w_ylo;
      w_ymax  = (w_yhi > c_ymax) ? c_ymax : w_yhi;
      w_empty = (w_xmin > w_xmax) || (w_ymin > w_ymax);
   end

   assign w_last = (r_tptx == r_xmax) && (r_tpty == r_ymax);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tst_req   = 1'b0;
      w_pix_valid = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_BBOX;
            end
         end
         S_BBOX: begin
            w_state_nxt = w_empty ? S_FIN : S_ISSUE;
         end
         S_ISSUE: begin
            w_tst_req   = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (tst_done) begin
               w_state_nxt = (tst_in || EMIT_ALL) ? S_EMIT : S_STEP;
            end
         end
         S_EMIT: begin
            w_pix_valid = 1'b1;
            if (pix_ready) begin
               w_state_nxt = S_STEP;
            end
         end
         S_STEP: begin
            w_state_nxt = w_last ? S_FIN : S_ISSUE;
         end
         S_FIN: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tp1x    <= '0;
         r_tp1y    <= '0;
         r_tp2x    <= '0;
         r_tp2y    <= '0;
         r_tp3x    <= '0;
         r_tp3y    <= '0;
         r_tptx    <= '0;
         r_tpty    <= '0;
         r_xmin    <= '0;
         r_xmax    <= '0;
         r_ymax    <= '0;
         r_pix_x   <= '0;
         r_pix_y   <= '0;
         r_pix_in  <= 1'b0;
         r_busy    <= 1'b0;
         r_pix_cnt <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_tp1x    <= v1x;
                  r_tp1y    <= v1y;
                  r_tp2x    <= v2x;
                  r_tp2y    <= v2y;
                  r_tp3x    <= v3x;
                  r_tp3y    <= v3y;
                  r_pix_cnt <= '0;
                  r_busy    <= 1'b1;
               end
            end
            S_BBOX: begin
               r_xmin <= w_xmin;
               r_xmax <= w_xmax;
               r_ymax <= w_ymax;
               if (!w_empty) begin
                  r_tptx <= w_xmin;
                  r_tpty <= w_ymin;
               end
            end
            S_WAIT: begin
               if (tst_done) begin
                  r_pix_x  <= r_tptx;
                  r_pix_y  <= r_tpty;
                  r_pix_in <= tst_in;
                  if (tst_in && (r_pix_cnt != '1)) begin
                     r_pix_cnt <= r_pix_cnt + 20'd1;
                  end
               end
            end
            S_STEP: begin
               if (r_tptx < r_xmax) begin
                  r_tptx <= r_tptx + c_one;
               end else begin
                  r_tptx <= r_xmin;
                  r_tpty <= r_tpty + c_one;
               end
            end
            S_FIN: begin
               r_busy <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign tp1x      = r_tp1x;
   assign tp1y      = r_tp1y;
   assign tp2x      = r_tp2x;
   assign tp2y      = r_tp2y;
   assign tp3x      = r_tp3x;
   assign tp3y      = r_tp3y;
   assign tptx      = r_tptx;
   assign tpty      = r_tpty;
   assign tst_req   = w_tst_req;
   assign pix_valid = w_pix_valid;
   assign pix_x     = r_pix_x;
   assign pix_y     = r_pix_y;
   assign pix_in    = r_pix_in;
   assign busy      = r_busy;
   assign done      = w_done;
   assign pix_cnt   = r_pix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tri_raster_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_raster_scan
// Brief    : Randomized bench for tri_raster_scan (EMIT_ALL=0 and =1 instances).
// Revision : 1.0
// ============================================================================
module tb_tri_raster_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] v1x, v1y, v2x, v2y, v3x, v3y;
   logic        start     [2];
   logic        tst_done  [2];
   logic        tst_in    [2];
   logic        pix_ready [2];
   logic [10:0] tp1x [2], tp1y [2], tp2x [2], tp2y [2], tp3x [2], tp3y [2];
   logic [10:0] tptx [2], tpty [2], pix_x [2], pix_y [2];
   logic        tst_req [2], pix_valid [2], pix_in [2], busy [2], done [2];
   logic [19:0] pix_cnt [2];

   int total = 0;
   int bad   = 0;
   int vx [3];
   int vy [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      tri_raster_scan #(.CW(11), .XMAX(639), .YMAX(479), .EMIT_ALL(g == 1)) u_dut (
         .clk(clk), .rst(rst), .start(start[g]),
         .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
         .tp1x(tp1x[g]), .tp1y(tp1y[g]), .tp2x(tp2x[g]), .tp2y(tp2y[g]),
         .tp3x(tp3x[g]), .tp3y(tp3y[g]), .tptx(tptx[g]), .tpty(tpty[g]),
         .tst_req(tst_req[g]), .tst_done(tst_done[g]), .tst_in(tst_in[g]),
         .pix_valid(pix_valid[g]), .pix_ready(pix_ready[g]),
         .pix_x(pix_x[g]), .pix_y(pix_y[g]), .pix_in(pix_in[g]),
         .busy(busy[g]), .done(done[g]), .pix_cnt(pix_cnt[g])
      );
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bench tester: edge-inclusive sign test on the three edge functions.
   function automatic bit ref_inside(input int px, input int py);
      int d1, d2, d3;
      d1 = (vx[1] - vx[0]) * (py - vy[0]) - (vy[1] - vy[0]) * (px - vx[0]);
      d2 = (vx[2] - vx[1]) * (py - vy[1]) - (vy[2] - vy[1]) * (px - vx[1]);
      d3 = (vx[0] - vx[2]) * (py - vy[2]) - (vy[0] - vy[2]) * (px - vx[2]);
      return ((d1 >= 0) && (d2 >= 0) && (d3 >= 0)) || ((d1 <= 0) && (d2 <= 0) && (d3 <= 0));
   endfunction

   task automatic drive_vertices();
      v1x = 11'(vx[0]); v1y = 11'(vy[0]);
      v2x = 11'(vx[1]); v2y = 11'(vy[1]);
      v3x = 11'(vx[2]); v3y = 11'(vy[2]);
   endtask

   task automatic scramble_vertices();
      v1x = 11'($urandom); v1y = 11'($urandom);
      v2x = 11'($urandom); v2y = 11'($urandom);
      v3x = 11'($urandom); v3y = 11'($urandom);
   endtask

   // rmode: 0 ready always, 1 ready toggling, 2 ready random
   task automatic run(input int k, input int rmode, input int maxlat, input bit midstart);
      int qx[$], qy[$], ex[$], ey[$], ef[$];
      int xmin, xmax, ymin, ymax, ninside, cyc, lat, hx, hy;
      bit waiting, fin, prev_stall, first, f;
      logic [10:0] sx, sy;
      logic        sf;
      xmin = imax(imin(imin(vx[0], vx[1]), vx[2]), 0);
      xmax = imin(imax(imax(vx[0], vx[1]), vx[2]), 639);
      ymin = imax(imin(imin(vy[0], vy[1]), vy[2]), 0);
      ymax = imin(imax(imax(vy[0], vy[1]), vy[2]), 479);
      ninside = 0;
      for (int y = ymin; y <= ymax; y++) begin
         for (int x = xmin; x <= xmax; x++) begin
            qx.push_back(x);
            qy.push_back(y);
            f = ref_inside(x, y);
            if (f) ninside++;
            if (f || (k == 1)) begin
               ex.push_back(x);
               ey.push_back(y);
               ef.push_back(int'(f));
            end
         end
      end
      @(negedge clk);
      drive_vertices();
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      scramble_vertices();
      chk("busy_rise", busy[k], 1);
      cyc = 1; fin = 0; waiting = 0; prev_stall = 0; first = 1; lat = 0; hx = 0; hy = 0;
      sx = '0; sy = '0; sf = 1'b0;
      while (!fin && (cyc < 20000)) begin
         @(negedge clk);
         cyc++;
         tst_done[k] = 1'b0;
         start[k] = midstart && (cyc == 8);
         if (tst_req[k]) begin
            if (first) begin
               chk("lat_tp1x", $signed(tp1x[k]), vx[0]); chk("lat_tp1y", $signed(tp1y[k]), vy[0]);
               chk("lat_tp2x", $signed(tp2x[k]), vx[1]); chk("lat_tp2y", $signed(tp2y[k]), vy[1]);
               chk("lat_tp3x", $signed(tp3x[k]), vx[2]); chk("lat_tp3y", $signed(tp3y[k]), vy[2]);
               chk("first_req_cycle", cyc, 2);
               first = 0;
            end
            if (qx.size() == 0) begin
               chk("extra_req", 1, 0);
            end else begin
               chk("req_x", tptx[k], qx.pop_front());
               chk("req_y", tpty[k], qy.pop_front());
            end
            hx = int'(tptx[k]); hy = int'(tpty[k]);
            lat = int'($urandom_range(maxlat, 0));
            waiting = 1;
         end else if (waiting) begin
            chk("hold_x", tptx[k], hx);
            chk("hold_y", tpty[k], hy);
            if (lat == 0) begin
               tst_done[k] = 1'b1;
               tst_in[k]   = ref_inside(hx, hy);
               waiting     = 0;
            end else begin
               lat--;
            end
         end
         case (rmode)
            0:       pix_ready[k] = 1'b1;
            1:       pix_ready[k] = cyc[0];
            default: pix_ready[k] = 1'($urandom_range(1, 0));
         endcase
         if (pix_valid[k]) begin
            if (prev_stall) begin
               chk("stall_x", pix_x[k], sx);
               chk("stall_y", pix_y[k], sy);
               chk("stall_f", pix_in[k], sf);
            end
            sx = pix_x[k]; sy = pix_y[k]; sf = pix_in[k];
            if (pix_ready[k]) begin
               if (ex.size() == 0) begin
                  chk("extra_pix", 1, 0);
               end else begin
                  chk("pix_x", pix_x[k], ex.pop_front());
                  chk("pix_y", pix_y[k], ey.pop_front());
                  chk("pix_in", pix_in[k], ef.pop_front());
               end
            end
            prev_stall = !pix_ready[k];
         end else begin
            prev_stall = 0;
         end
         if (done[k]) begin
            fin = 1;
            chk("pix_cnt", pix_cnt[k], ninside);
            chk("missing_req", qx.size(), 0);
            chk("missing_pix", ex.size(), 0);
            if (xmin > xmax || ymin > ymax) chk("empty_done_cycle", cyc, 2);
         end
      end
      if (!fin) chk("timeout", 0, 1);
      tst_done[k]  = 1'b0;
      @(negedge clk);
      pix_ready[k] = 1'b0;
      chk("done_pulse", done[k], 0);
      chk("busy_fall", busy[k], 0);
   endtask

   // mode 0: reset in WAIT; mode 1: reset while a pixel is stalled in EMIT
   task automatic abort_run(input int mode);
      bit seen;
      int ndone;
      vx = '{0, 4, 0}; vy = '{0, 0, 4};
      @(negedge clk);
      drive_vertices();
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      pix_ready[0] = 1'b0;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         tst_done[0] = 1'b0;
         if (mode == 0 && seen) break;
         if (mode == 1 && pix_valid[0]) break;
         if (seen) begin
            tst_done[0] = 1'b1;
            tst_in[0]   = 1'b1;
         end
         if (tst_req[0]) seen = 1;
      end
      chk("pre_abort_busy", busy[0], 1);
      if (mode == 1) chk("pre_abort_valid", pix_valid[0], 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_req", tst_req[0], 0);
      chk("abort_valid", pix_valid[0], 0);
      chk("abort_busy", busy[0], 0);
      chk("abort_cnt", pix_cnt[0], 0);
      chk("abort_tp", {tptx[0], tpty[0], tp2x[0], tp3y[0], pix_in[0]}, 0);
      ndone = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done[0]) ndone++;
      end
      chk("abort_no_done", ndone, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = '{1'b0, 1'b0}; tst_done = '{1'b0, 1'b0};
      tst_in = '{1'b0, 1'b0}; pix_ready = '{1'b0, 1'b0};
      v1x = '0; v1y = '0; v2x = '0; v2y = '0; v3x = '0; v3y = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", busy[k], 0);
         chk("rst_req", tst_req[k], 0);
         chk("rst_valid", pix_valid[k], 0);
         chk("rst_done", done[k], 0);
         chk("rst_cnt", pix_cnt[k], 0);
         chk("rst_pt", {tptx[k], tpty[k], tp1x[k], pix_x[k]}, 0);
      end
      rst = 1'b0;

      vx = '{0, 4, 0}; vy = '{0, 0, 4};
      run(0, 0, 0, 1'b0);
      chk("t1_cnt", pix_cnt[0], 15);
      run(1, 1, 0, 1'b0);
      chk("t2_cnt", pix_cnt[1], 15);

      vx = '{-5, 2, -5}; vy = '{-5, -5, 3};
      run(0, 0, 2, 1'b1);
      vx = '{700, 800, 750}; vy = '{10, 10, 90};
      run(0, 0, 0, 1'b0);
      chk("offscreen_cnt", pix_cnt[0], 0);

      vx = '{7, 7, 7}; vy = '{7, 7, 7};
      run(0, 0, 3, 1'b0);
      chk("point_cnt", pix_cnt[0], 1);
      run(1, 2, 3, 1'b0);

      abort_run(0);
      vx = '{1, 6, 2}; vy = '{2, 3, 7};
      run(0, 2, 4, 1'b0);
      abort_run(1);
      vx = '{0, 4, 0}; vy = '{0, 0, 4};
      run(0, 1, 1, 1'b0);
      chk("post_abort_cnt", pix_cnt[0], 15);

      for (int i = 0; i < 10; i++) begin
         int bx, by;
         bx = int'($urandom_range(660, 0)) - 10;
         by = int'($urandom_range(500, 0)) - 10;
         for (int j = 0; j < 3; j++) begin
            vx[j] = bx + int'($urandom_range(12, 0));
            vy[j] = by + int'($urandom_range(12, 0));
         end
         run(i % 2, 2, 9, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
